// File: rtl/tinyfpga_gpio_bank.sv
// GPIO bank: per-pad direction/output registers, input sync, edge status, IRQ.
// Optional input debounce filter is built when GPIO_DEBOUNCE_EN is defined.
module tinyfpga_gpio_bank #(
    parameter int NUM_PINS        = 18,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    inout  wire  [NUM_PINS-1:0] pin,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [2:0]          req_addr,
    input  logic [31:0]         req_wdata,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic                irq
);

    if (NUM_PINS < 1 || NUM_PINS > 32) begin : g_bad_pins
        $error("NUM_PINS must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be >= 2");
    end

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_wr;
    logic                w_rd;
    logic [NUM_PINS-1:0] w_wd;
    logic [NUM_PINS-1:0] r_out;
    logic [NUM_PINS-1:0] r_oe;
    logic [NUM_PINS-1:0] r_rise_en;
    logic [NUM_PINS-1:0] r_fall_en;
    logic [NUM_PINS-1:0] r_status;
    logic [NUM_PINS-1:0] r_sync1;
    logic [NUM_PINS-1:0] r_sync2;
    logic [NUM_PINS-1:0] w_filt;
    logic [NUM_PINS-1:0] r_filt_q;
    logic [NUM_PINS-1:0] w_set;
    logic [NUM_PINS-1:0] w_clr;
    logic [31:0]         w_rd_data;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_irq;
    logic                w_unused_wdata;

    assign w_wd           = req_wdata[NUM_PINS-1:0];
    assign w_unused_wdata = &{1'b0, req_wdata};

    // Bus FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus FSM next state; ACK lasts one cycle and qualifies the access
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                req_ready   = 1'b1;
                w_wr        = req_write;
                w_rd        = ~req_write;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control registers; writes to IN and unknown side effects are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out     <= '0;
            r_oe      <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            case (req_addr)
                3'd0:    r_out     <= w_wd;
                3'd1:    r_oe      <= w_wd;
                3'd4:    r_rise_en <= w_wd;
                3'd5:    r_fall_en <= w_wd;
                3'd6:    r_out     <= r_out | w_wd;
                3'd7:    r_out     <= r_out & ~w_wd;
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_pad
        assign pin[g] = r_oe[g] ? r_out[g] : 1'bz;
    end

    // Two-flop synchroniser plus delayed copy of the filtered value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_filt_q <= '0;
        end else begin
            r_sync1  <= pin;
            r_sync2  <= r_sync1;
            r_filt_q <= w_filt;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [CW-1:0]       r_cnt [NUM_PINS];
    logic [NUM_PINS-1:0] r_filt;

    // Counter runs only while the synced input disagrees with the filter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt <= '0;
            for (int i = 0; i < NUM_PINS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PINS; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_sync2;
`endif

    assign w_set = (w_filt & ~r_filt_q & r_rise_en)
                 | (~w_filt & r_filt_q & r_fall_en);
    assign w_clr = (w_wr && req_addr == 3'd3) ? w_wd : '0;

    // Sticky status; a set in the same cycle as its clear survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_clr) | w_set;
            r_irq    <= |r_status;
        end
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        w_rd_data = '0;
        case (req_addr)
            3'd0:    w_rd_data[NUM_PINS-1:0] = r_out;
            3'd1:    w_rd_data[NUM_PINS-1:0] = r_oe;
            3'd2:    w_rd_data[NUM_PINS-1:0] = w_filt;
            3'd3:    w_rd_data[NUM_PINS-1:0] = r_status;
            3'd4:    w_rd_data[NUM_PINS-1:0] = r_rise_en;
            3'd5:    w_rd_data[NUM_PINS-1:0] = r_fall_en;
            default: w_rd_data = '0;
        endcase
    end

    // Read response registered one cycle after ACK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_rd;
            r_rsp_rdata <= w_rd ? w_rd_data : '0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign irq       = r_irq;

endmodule
